// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised line, mid-bit sampling, valid/ready word output.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115200,
    parameter int CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rxsig,
    output logic [DATA_WIDTH-1:0] rxdata,
    output logic                  rxvalid,
    input  logic                  rxready,
    output logic                  rxerr,
    output logic                  rxovf
);

    localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CW               = $clog2(PULSE_WIDTH + 1);
    localparam int BW               = $clog2(DATA_WIDTH + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                state_q, state_d;
    logic [1:0]            sync_q;
    logic                  line;
    logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  armed_q, armed_d;
    logic                  word_done, frame_bad;
`ifdef UART_RX_PARITY_EN
    logic                  par_err_q, par_err_d;
`endif

    assign line = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[0], rxsig};
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        armed_d   = armed_q;
        word_done = 1'b0;
        frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            IDLE: begin
                // Only a falling edge after a seen-high line starts a frame.
                if (line) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d   = START;
                    clk_cnt_d = CW'(HALF_PULSE_WIDTH - 1);
                    armed_d   = 1'b0;
                end
            end
            START: begin
                if (clk_cnt_q != '0) begin
                    clk_cnt_d = clk_cnt_q - 1'b1;
                end else if (!line) begin
                    state_d   = DATA;
                    clk_cnt_d = CW'(PULSE_WIDTH - 1);
                    bit_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (clk_cnt_q != '0) begin
                    clk_cnt_d = clk_cnt_q - 1'b1;
                end else begin
                    shift_d   = {line, shift_q[DATA_WIDTH-1:1]};
                    clk_cnt_d = CW'(PULSE_WIDTH - 1);
                    if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_cnt_q != '0) begin
                    clk_cnt_d = clk_cnt_q - 1'b1;
                end else begin
                    // Even parity: the parity bit equals the XOR of the data bits.
                    par_err_d = line ^ (^shift_q);
                    state_d   = STOP;
                    clk_cnt_d = CW'(PULSE_WIDTH - 1);
                end
            end
`endif
            STOP: begin
                if (clk_cnt_q != '0) begin
                    clk_cnt_d = clk_cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    if (line && !par_err_q) word_done = 1'b1;
                    else                    frame_bad = 1'b1;
`else
                    if (line) word_done = 1'b1;
                    else      frame_bad = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxdata  <= '0;
            rxvalid <= 1'b0;
            rxerr   <= 1'b0;
            rxovf   <= 1'b0;
        end else begin
            rxerr <= frame_bad;
            // A word landing on a consumed slot is a plain reload, not an overflow.
            rxovf <= word_done && rxvalid && !rxready;
            if (word_done) begin
                rxdata  <= shift_q;
                rxvalid <= 1'b1;
            end else if (rxvalid && rxready) begin
                rxvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx; bit period scaled to 32 clocks (half period 16) to keep runs short.
module tb_uart_rx;
    localparam int P   = 32;
    localparam int LAT = 2 + (P / 2 - 1) + 9 * P + 1;  // 306 clocks, +/-1

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rxsig = 1'b1;
    logic [7:0] rxdata;
    logic       rxvalid;
    logic       rxready = 1'b0;
    logic       rxerr;
    logic       rxovf;

    int tests = 0, fails = 0;
    int cyc = 0, n_err = 0, n_ovf = 0;

    uart_rx #(.DATA_WIDTH(8), .BAUD_RATE(100_000), .CLK_FREQ(3_200_000)) dut (
        .clk(clk), .rst(rst), .rxsig(rxsig), .rxdata(rxdata), .rxvalid(rxvalid),
        .rxready(rxready), .rxerr(rxerr), .rxovf(rxovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rxerr) n_err++;
        if (rxovf) n_ovf++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxsig = b;
        repeat (P) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(par_b);
`else
        if (par_b === 1'bx) rxsig = 1'b0;
`endif
        send_bit(stop_b);
        rxsig = 1'b1;
        repeat (P) @(negedge clk);
    endtask

    task automatic consume();
        rxready = 1'b1;
        @(negedge clk);
        rxready = 1'b0;
    endtask

    int t0, lat, e0, o0;

    initial begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", {31'd0, rxvalid}, 32'd0);
        chk("rst_data", {24'd0, rxdata}, 32'd0);
        chk("rst_err", {31'd0, rxerr}, 32'd0);
        chk("rst_ovf", {31'd0, rxovf}, 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 0xA5, latency from falling edge of the start bit
        t0 = cyc; lat = -1;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                for (int i = 0; i < 1000 && lat < 0; i++) begin
                    @(negedge clk);
                    if (rxvalid) lat = cyc - t0;
                end
            end
        join
        chk("a5_lat_window", {31'd0, (lat >= LAT - 1 && lat <= LAT + 1)}, 32'd1);
        chk("a5_data", {24'd0, rxdata}, 32'hA5);
        repeat (50) @(negedge clk);
        chk("a5_hold", {31'd0, rxvalid}, 32'd1);
        consume();
        chk("a5_consumed", {31'd0, rxvalid}, 32'd0);
        chk("a5_no_err", 32'(n_err), 32'd0);

        // short low glitch on idle line
        rxsig = 1'b0;
        repeat (8) @(negedge clk);
        rxsig = 1'b1;
        repeat (3 * P) @(negedge clk);
        chk("glitch_valid", {31'd0, rxvalid}, 32'd0);
        chk("glitch_err", 32'(n_err), 32'd0);
        chk("glitch_idle", 32'(dut.state_q), 32'd0);

        // bad stop bit, then a good frame
        send_frame(8'h3C, 1'b0, 1'b0);
        chk("stop0_err", 32'(n_err), 32'd1);
        chk("stop0_valid", {31'd0, rxvalid}, 32'd0);
        send_frame(8'h11, 1'b1, 1'b0);
        chk("after_err_valid", {31'd0, rxvalid}, 32'd1);
        chk("after_err_data", {24'd0, rxdata}, 32'h11);
        consume();

        // overwrite without consume
        o0 = n_ovf;
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h02, 1'b1, 1'b1);
        chk("ovf_count", 32'(n_ovf - o0), 32'd1);
        chk("ovf_data", {24'd0, rxdata}, 32'h02);
        chk("ovf_valid", {31'd0, rxvalid}, 32'd1);
        consume();
        chk("ovf_consumed", {31'd0, rxvalid}, 32'd0);

        // reset during the 4th data bit; remaining line bits are high so nothing restarts
        e0 = n_err;
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (4 * P + P / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        chk("abort_valid", {31'd0, rxvalid}, 32'd0);
        chk("abort_err", 32'(n_err - e0), 32'd0);
        chk("abort_idle", 32'(dut.state_q), 32'd0);
        send_frame(8'h7E, 1'b1, 1'b0);
        chk("post_rst_valid", {31'd0, rxvalid}, 32'd1);
        chk("post_rst_data", {24'd0, rxdata}, 32'h7E);
        consume();

`ifdef UART_RX_PARITY_EN
        e0 = n_err;
        send_frame(8'h07, 1'b1, 1'b0);
        chk("par_bad_err", 32'(n_err - e0), 32'd1);
        chk("par_bad_valid", {31'd0, rxvalid}, 32'd0);
        send_frame(8'h07, 1'b1, 1'b1);
        chk("par_ok_valid", {31'd0, rxvalid}, 32'd1);
        chk("par_ok_data", {24'd0, rxdata}, 32'h07);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame.
REQ-002 The module SHALL have parameter BAUD_RATE, default 115200, giving the line bit rate.
REQ-003 The module SHALL have parameter CLK_FREQ, default 100_000_000, giving the clk frequency in Hz.
REQ-004 The module SHALL derive PULSE_WIDTH = CLK_FREQ/BAUD_RATE (integer division) and HALF_PULSE_WIDTH = PULSE_WIDTH/2.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port rxsig, input, 1 bit: the asynchronous serial line, idle high.
REQ-008 The module SHALL have port rxdata, output, DATA_WIDTH bits: the last received data word.
REQ-009 The module SHALL have port rxvalid, output, 1 bit: rxdata holds an unconsumed word.
REQ-010 The module SHALL have port rxready, input, 1 bit: the consumer accepts rxdata this cycle.
REQ-011 The module SHALL have port rxerr, output, 1 bit: a one-cycle pulse on a framing (or parity) error.
REQ-012 The module SHALL have port rxovf, output, 1 bit: a one-cycle pulse when an unconsumed word is overwritten.

Function
REQ-013 rxsig SHALL pass through a 2-flop synchronizer (reset value 1); all decisions SHALL use the synchronized value.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only) and STOP; each non-IDLE state SHALL count clk_cnt down to 0 and then sample.
REQ-015 IDLE: when armed and the synced line is 0 at cycle n, the FSM SHALL go to START with clk_cnt = HALF_PULSE_WIDTH-1, sampling the start bit at cycle n+HALF_PULSE_WIDTH-1.
REQ-016 armed SHALL be set by any cycle with the synced line at 1 in IDLE and cleared on leaving IDLE, so a held-low line never retriggers.
REQ-017 START sample: 0 -> DATA with clk_cnt = PULSE_WIDTH-1 and bit_cnt = 0; 1 -> IDLE with no output (glitch reject).
REQ-018 DATA SHALL sample DATA_WIDTH bits LSB first, one per PULSE_WIDTH cycles, then enter PARITY (macro) or STOP with clk_cnt = PULSE_WIDTH-1.
REQ-019 STOP sample 1: the shift register SHALL load rxdata and rxvalid SHALL be 1 on the next cycle; the FSM SHALL return to IDLE.
REQ-020 STOP sample 0: the word SHALL be discarded, rxerr SHALL pulse for one cycle, rxdata/rxvalid SHALL be unchanged, and the FSM SHALL return to IDLE (not armed).
REQ-021 rxvalid SHALL clear on the cycle after rxvalid && rxready and SHALL otherwise hold.
REQ-022 A frame completing while rxvalid=1 and rxready=0 SHALL overwrite rxdata, keep rxvalid=1 and pulse rxovf.
REQ-023 A frame completing in the same cycle as rxvalid && rxready SHALL load the new word, keep rxvalid=1 and not pulse rxovf.
REQ-024 rxready SHALL be ignored while rxvalid=0.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, armed=0, synchronizer=1, counters=0, rxdata=0, rxvalid=0, rxerr=0, rxovf=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no output; after release the next start SHALL be accepted only after the line is seen high.

Configuration
REQ-027 With macro UART_RX_PARITY_EN defined, PARITY SHALL sample one even-parity bit after the data bits; on mismatch the word SHALL be discarded and rxerr SHALL pulse in the STOP-sample cycle, regardless of the stop bit.
REQ-028 Without UART_RX_PARITY_EN, no PARITY state or logic SHALL exist, and the frame SHALL be start, DATA_WIDTH bits and stop.

Verification
REQ-029 Defaults, frame 0xA5 with a valid stop bit, rxready=0 -> rxdata=0xA5, rxvalid=1 at 2+433+9*868+1 = 8248 cycles (+/-1) after the falling edge of rxsig, held until rxready=1.
REQ-030 A 200-cycle low glitch on an idle line -> no rxvalid, no rxerr, and the FSM back in IDLE.
REQ-031 Frame 0x3C with stop bit 0 -> one rxerr pulse, rxvalid stays 0, and the following frame 0x11 is received correctly.
REQ-032 Frames 0x01 then 0x02 with rxready=0 -> rxovf pulses once, rxdata=0x02; rxready=1 -> rxvalid clears the next cycle.
REQ-033 rst pulsed during the 4th data bit, then frame 0x7E -> no output from the aborted frame, then rxdata=0x7E.
REQ-034 UART_RX_PARITY_EN defined, 0x07 sent with parity bit 0 -> rxerr pulse, no rxvalid; the same byte with parity bit 1 -> rxdata=0x07.
